// File: rtl/reaction_pkg.sv
// Shared types for the two-player reaction timer controller:
// one-hot FSM states, winner codes and the BCD digit type.
package reaction_pkg;

    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        ARM        = 6'b000010,
        WAIT       = 6'b000100,
        RACE       = 6'b001000,
        RESULT     = 6'b010000,
        MATCH_OVER = 6'b100000
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P0   = 2'b01;
    localparam logic [1:0] W_P1   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    typedef logic [3:0] bcd_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/duel_score_keeper.sv
// Two saturating point counters plus a registered "someone reached the
// winning score" flag.
module duel_score_keeper
    import reaction_pkg::*;
#(
    parameter int WIN_SCORE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc0,
    input  logic       inc1,
    input  logic       clr,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       match_won
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    logic [3:0] next0;
    logic [3:0] next1;

    always_comb begin
        next0 = inc0 ? sat_inc(score0) : score0;
        next1 = inc1 ? sat_inc(score1) : score1;
    end

    // Compare on the next values so match_won is valid in the same cycle
    // as the score that caused it.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            score0    <= 4'd0;
            score1    <= 4'd0;
            match_won <= 1'b0;
        end else begin
            score0    <= next0;
            score1    <= next1;
            match_won <= (next0 >= WIN) || (next1 >= WIN);
        end
    end

endmodule

// File: rtl/duel_reaction_ctrl.sv
// Round sequencer for the duel reaction timer: arms the random delay, races
// the stopwatch, arbitrates presses and false starts, and tracks the match.
module duel_reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int   WIN_SCORE = 3,
    parameter bcd_t TMO_D3    = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       clear_btn,
    input  logic       p0_btn,
    input  logic       p1_btn,
    input  logic       cnt_zero,
    input  bcd_t       sw_d3,
    input  bcd_t       sw_d2,
    input  bcd_t       sw_d1,
    input  bcd_t       sw_d0,
    output logic       cnt_load,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       sw_go,
    output logic       sw_clr,
    output logic       led_go,
    output logic [1:0] winner,
    output logic [1:0] foul,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output bcd_t       t_d3,
    output bcd_t       t_d2,
    output bcd_t       t_d1,
    output bcd_t       t_d0,
    output logic [3:0] round_num,
    output logic       match_done
);

    state_t state;
    state_t next_state;
    logic   inc0;
    logic   inc1;
    logic   match_won;

    logic any_press;
    logic timeout;
    logic clean_win;

    assign any_press = p0_btn || p1_btn;
    assign timeout   = (sw_d3 == TMO_D3) && (sw_d2 == 4'd0) && (sw_d1 == 4'd0) && (sw_d0 == 4'd0);
    assign clean_win = (winner != W_NONE) && (foul == 2'b00);

    duel_score_keeper #(.WIN_SCORE(WIN_SCORE)) u_score (
        .clk       (clk),
        .rst       (rst),
        .inc0      (inc0),
        .inc1      (inc1),
        .clr       (clear_btn),
        .score0    (score0),
        .score1    (score1),
        .match_won (match_won)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        sw_go      = 1'b0;
        sw_clr     = 1'b0;
        led_go     = 1'b0;
        match_done = 1'b0;
        inc0       = 1'b0;
        inc1       = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                sw_clr  = 1'b1;
                if (start_btn) next_state = ARM;
            end
            ARM: begin
                cnt_load   = 1'b1;
                sw_clr     = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                cnt_en = 1'b1;
                // A false start hands the point to the opponent.
                if (any_press) begin
                    next_state = RESULT;
                    inc1       = p0_btn && !p1_btn;
                    inc0       = p1_btn && !p0_btn;
                end else if (cnt_zero) begin
                    next_state = RACE;
                end
            end
            RACE: begin
                sw_go  = 1'b1;
                led_go = 1'b1;
                if (any_press) begin
                    next_state = RESULT;
                    inc0       = p0_btn && !p1_btn;
                    inc1       = p1_btn && !p0_btn;
                end else if (timeout) begin
                    next_state = RESULT;
                end
            end
            RESULT: begin
                led_go = clean_win;
                if (match_won) next_state = MATCH_OVER;
                else if (start_btn) next_state = ARM;
            end
            MATCH_OVER: begin
                match_done = 1'b1;
                led_go     = clean_win;
            end
            default: next_state = IDLE;
        endcase
        if (clear_btn) begin
            next_state = IDLE;
            inc0       = 1'b0;
            inc1       = 1'b0;
        end
    end

    // Winner bit order matches the press vector: {p1,p0} in a race, swapped
    // in WAIT because the foul awards the other player.
    always_ff @(posedge clk) begin
        if (!rst || clear_btn) begin
            winner    <= W_NONE;
            foul      <= 2'b00;
            t_d3      <= 4'd0;
            t_d2      <= 4'd0;
            t_d1      <= 4'd0;
            t_d0      <= 4'd0;
            round_num <= 4'd0;
        end else begin
            case (state)
                ARM: begin
                    winner <= W_NONE;
                    foul   <= 2'b00;
                end
                WAIT: begin
                    if (any_press) begin
                        winner    <= {p0_btn, p1_btn};
                        foul      <= {p1_btn, p0_btn};
                        round_num <= sat_inc(round_num);
                    end
                end
                RACE: begin
                    if (any_press || timeout) begin
                        winner    <= {p1_btn, p0_btn};
                        t_d3      <= sw_d3;
                        t_d2      <= sw_d2;
                        t_d1      <= sw_d1;
                        t_d0      <= sw_d0;
                        round_num <= sat_inc(round_num);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
